mc_ctrl: RTL
============

# mc_ctrl

Multi-cycle control unit for the MIPS datapath. Sequences instruction fetch, decode, execute, memory and write-back over a shared single-port memory and the shared ALU, producing all datapath enables and the 3-bit ALU operation code. It also guards register write-back against signed ALU overflow and counts retired instructions. Sits between the instruction register / memory interface and the datapath muxes, register file and ALU.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26], stable after IR load
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- overflow  in  1  ALU signed-overflow flag
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  store (valid with mem_req)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_we  out  1  load IR
- pc_we  out  1  write PC
- pc_src  out  2  00 = ALU result, 01 = ALUOut (branch target), 10 = jump target
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 = rt, 01 = constant 4, 10 = extended imm, 11 = sign-ext imm << 2
- ext_zero  out  1  immediate extender zero-extends (ori, lui)
- alu_ctrl  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 011 XOR, 101 LUI, 111 SLT
- reg_we  out  1  register-file write
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- ovf_exc  out  1  one-cycle pulse: write suppressed by overflow
- illegal  out  1  one-cycle pulse: unsupported opcode/funct
- state  out  4  current state, for debug
- retired  out  CNT_W  completed-instruction count

## Operation
- States: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REX 6, IEX 7, ALUWB 8, BEQ 9, JUMP 10. Codes 11–15 are unreachable and recover to FETCH.
- FETCH: mem_req, iord=0, alu_src_a=0, alu_src_b=01, ADD, pc_src=00. ir_we and pc_we are asserted only when mem_ready=1. The block holds in FETCH until mem_ready=1, then moves to DECODE.
- DECODE: alu_src_a=0, alu_src_b=11, ADD (computes branch target). Next state by opcode:
  - lw 100011 / sw 101011 → MEMADR
  - R-type 000000 with funct add 100000, sub 100010, and 100100, or 100101, xor 100110, slt 101010 → REX
  - addi 001000, ori 001101, lui 001111 → IEX
  - beq 000100 → BEQ
  - j 000010 → JUMP
  - anything else → FETCH, with illegal=1 for this cycle
- MEMADR: alu_src_a=1, alu_src_b=10, ADD. Goes to MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req, iord=1. Waits for mem_ready, then MEMWB.
- MEMWB: reg_we, reg_dst=0, mem_to_reg=1. Then FETCH.
- MEMWR: mem_req, mem_we, iord=1. Waits for mem_ready, then FETCH.
- REX: alu_src_a=1, alu_src_b=00, alu_ctrl from funct. Then ALUWB.
- IEX: alu_src_a=1, alu_src_b=10. addi uses ADD with sign extension. ori uses OR with ext_zero=1. lui uses LUI with ext_zero=1. Then ALUWB.
- In REX and IEX, ovf_q <= overflow when alu_ctrl is ADD or SUB, else 0.
- ALUWB: mem_to_reg=0, reg_dst=1 for R-type and 0 for I-type. reg_we = ~ovf_q; ovf_exc = ovf_q. Then FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, SUB, pc_src=01, pc_we = zero. overflow is ignored. Then FETCH.
- JUMP: pc_src=10, pc_we=1. Then FETCH.
- retired increments on every transition into FETCH from MEMWB, MEMWR, ALUWB, BEQ or JUMP. It wraps modulo 2^CNT_W. Illegal instructions and overflow-suppressed writes still count.
- mem_ready is ignored whenever mem_req=0.

## Timing
- Output decode is Moore on state plus the latched IR fields. The exceptions are ir_we/pc_we in FETCH and pc_we in BEQ, which combine state with mem_ready or zero.
- All outputs are 0 while rst=1; state resets to FETCH, retired to 0, ovf_q to 0.
- Reset mid-instruction: the next edge returns to FETCH. mem_req drops during the reset cycle, and a late mem_ready is ignored.
- Cycle counts with zero-wait memory: lw 5, sw 4, R/I-type 4, beq 3, j 3, illegal 2. Each wait cycle adds one.

## Structure
- Shared package mips_pkg holds the opcode and funct constants, the ALU code constants (shared with the ALU), and the state encoding.
- One combinational sub-module, mc_ctrl_dec, maps opcode/funct to an instruction class, an ALU code, and legal/ext_zero flags.

## Test plan
- Reset held 2 cycles, then add $3,$1,$2 with ready tied 1 → states 0,1,6,8,0; reg_we=1 in ALUWB with reg_dst=1; alu_ctrl=010; retired=1.
- lw with mem_ready delayed 3 cycles in FETCH and 2 in MEMRD → mem_req held throughout, ir_we a single pulse, total 10 cycles, MEMWB with mem_to_reg=1.
- add with overflow=1 in REX → reg_we=0 and ovf_exc=1 in ALUWB; retired still increments.
- beq with zero=1 → pc_we=1, pc_src=01; with zero=0 → pc_we=0.
- opcode 111111 → illegal pulses in DECODE, next state FETCH, no reg_we.
- rst asserted during MEMWR while mem_ready=0 → FETCH next cycle, mem_we=0, retired unchanged.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode/funct constants, ALU codes (also used by the ALU), control states.
// No logic; constants and types only.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_LUI = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REX    = 4'd6,
    S_IEX    = 4'd7,
    S_ALUWB  = 4'd8,
    S_BEQ    = 4'd9,
    S_JUMP   = 4'd10
  } state_t;

  typedef enum logic [2:0] {
    C_MEM, C_RTYPE, C_ITYPE, C_BEQ, C_JUMP, C_ILL
  } iclass_t;

endpackage

// File: rtl/mc_ctrl_dec.sv
// Instruction decoder: opcode/funct -> class, ALU code, legal and zero-extend flags.
// Purely combinational, no handshake.
module mc_ctrl_dec
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output iclass_t    iclass,
  output logic [2:0] alu_code,
  output logic       legal,
  output logic       ext_zero
);

  always_comb begin
    iclass   = C_ILL;
    alu_code = ALU_ADD;
    ext_zero = 1'b0;
    case (opcode)
      OP_LW, OP_SW: iclass = C_MEM;
      OP_RTYPE: begin
        iclass = C_RTYPE;
        case (funct)
          FN_ADD:  alu_code = ALU_ADD;
          FN_SUB:  alu_code = ALU_SUB;
          FN_AND:  alu_code = ALU_AND;
          FN_OR:   alu_code = ALU_OR;
          FN_XOR:  alu_code = ALU_XOR;
          FN_SLT:  alu_code = ALU_SLT;
          default: iclass   = C_ILL;
        endcase
      end
      OP_ADDI: iclass = C_ITYPE;
      OP_ORI: begin
        iclass   = C_ITYPE;
        alu_code = ALU_OR;
        ext_zero = 1'b1;
      end
      OP_LUI: begin
        iclass   = C_ITYPE;
        alu_code = ALU_LUI;
        ext_zero = 1'b1;
      end
      OP_BEQ: begin
        iclass   = C_BEQ;
        alu_code = ALU_SUB;
      end
      OP_J:    iclass = C_JUMP;
      default: iclass = C_ILL;
    endcase
  end

  assign legal = (iclass != C_ILL);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control FSM: fetch/decode/execute/mem/writeback enables, overflow guard, retire count.
// 2..5 cycles per instruction; FETCH and MEMRD/MEMWR stall until mem_ready.
module mc_ctrl
  import mips_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             overflow,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ext_zero,
  output logic [2:0]       alu_ctrl,
  output logic             reg_we,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             ovf_exc,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_t           state_q, state_d;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;
  logic             retire;

  iclass_t          iclass;
  logic [2:0]       dec_alu;
  logic             dec_legal;
  logic             dec_ext_zero;

  mc_ctrl_dec u_dec (
    .opcode   (opcode),
    .funct    (funct),
    .iclass   (iclass),
    .alu_code (dec_alu),
    .legal    (dec_legal),
    .ext_zero (dec_ext_zero)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      // Only add/sub can overflow; logical ops must not block the write.
      if (state_q == S_REX || state_q == S_IEX)
        ovf_q <= overflow && (alu_ctrl == ALU_ADD || alu_ctrl == ALU_SUB);
      if (retire)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    ext_zero   = 1'b0;
    alu_ctrl   = ALU_AND;
    reg_we     = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    ovf_exc    = 1'b0;
    illegal    = 1'b0;
    if (!rst) begin
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b01;
          alu_ctrl  = ALU_ADD;
          ir_we     = mem_ready;
          pc_we     = mem_ready;
          if (mem_ready) state_d = S_DECODE;
        end
        S_DECODE: begin
          alu_src_b = 2'b11;
          alu_ctrl  = ALU_ADD;
          if (!dec_legal) begin
            illegal = 1'b1;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            case (iclass)
              C_MEM:   state_d = S_MEMADR;
              C_RTYPE: state_d = S_REX;
              C_ITYPE: state_d = S_IEX;
              C_BEQ:   state_d = S_BEQ;
              C_JUMP:  state_d = S_JUMP;
              default: state_d = S_FETCH;
            endcase
          end
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_ctrl  = ALU_ADD;
          state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) state_d = S_MEMWB;
        end
        S_MEMWB: begin
          reg_we     = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEMWR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
          if (mem_ready) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_REX: begin
          alu_src_a = 1'b1;
          alu_ctrl  = dec_alu;
          state_d   = S_ALUWB;
        end
        S_IEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
          alu_ctrl  = dec_alu;
          ext_zero  = dec_ext_zero;
          state_d   = S_ALUWB;
        end
        S_ALUWB: begin
          reg_dst = (iclass == C_RTYPE);
          reg_we  = ~ovf_q;
          ovf_exc = ovf_q;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
        S_BEQ: begin
          alu_src_a = 1'b1;
          alu_ctrl  = ALU_SUB;
          pc_src    = 2'b01;
          pc_we     = zero;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end
        S_JUMP: begin
          pc_src  = 2'b10;
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign state   = rst ? 4'd0 : state_q;
  assign retired = rst ? '0 : cnt_q;

endmodule
